// File: rtl/fft_ctrl_pkg.sv
// rtl/fft_ctrl_pkg.sv - shared types and helpers for the FFT frame controller
package fft_ctrl_pkg;

  // Input side: fill a frame, let the FFT settle, then wait for the drain side
  typedef enum logic [1:0] {
    IN_IDLE   = 2'd0,
    IN_FILL   = 2'd1,
    IN_SETTLE = 2'd2,
    IN_HOLD   = 2'd3
  } in_state_t;

  // Output side: idle until a capture, then stream one bin per handshake
  typedef enum logic {
    OUT_IDLE  = 1'b0,
    OUT_DRAIN = 1'b1
  } out_state_t;

  localparam int FRAME_CNT_W = 16;

  // Width of a slot/bin index within one frame
  function automatic int sample_idx_w(input int buffer_size);
    return $clog2(buffer_size);
  endfunction

endpackage

// File: rtl/fft_bin_streamer.sv
// rtl/fft_bin_streamer.sv - captures FFT bins and streams them out one per handshake
module fft_bin_streamer
  import fft_ctrl_pkg::*;
#(
  parameter int SAMPLE_SIZE = 32,
  parameter int BUFFER_SIZE = 32
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 capture,
  input  logic [SAMPLE_SIZE*BUFFER_SIZE-1:0]   frame_in,
  output logic                                 idle,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [SAMPLE_SIZE-1:0]               out_data,
  output logic [sample_idx_w(BUFFER_SIZE)-1:0] out_index,
  output logic                                 out_last,
  output logic [FRAME_CNT_W-1:0]               frame_count
);

  localparam int               IDX_W    = sample_idx_w(BUFFER_SIZE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BUFFER_SIZE - 1);

  out_state_t                         r_state;
  out_state_t                         w_state_nxt;
  logic [SAMPLE_SIZE*BUFFER_SIZE-1:0] r_bins;
  logic [IDX_W-1:0]                   r_rd_idx;
  logic [FRAME_CNT_W-1:0]             r_frame_count;
  logic                               w_load;
  logic                               w_beat;
  logic                               w_done;

  // A capture is only honoured while idle so an in-flight frame is never overwritten
  assign w_load = capture && (r_state == OUT_IDLE);
  assign w_beat = (r_state == OUT_DRAIN) && out_ready;
  assign w_done = w_beat && (r_rd_idx == LAST_IDX);

  // Output FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= OUT_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Output FSM next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      OUT_IDLE:  if (w_load) w_state_nxt = OUT_DRAIN;
      OUT_DRAIN: if (w_done) w_state_nxt = OUT_IDLE;
      default:   w_state_nxt = OUT_IDLE;
    endcase
  end

  // Bin register, read pointer and completed-frame counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bins        <= '0;
      r_rd_idx      <= '0;
      r_frame_count <= '0;
    end else begin
      if (w_load) begin
        r_bins   <= frame_in;
        r_rd_idx <= '0;
      end else if (w_beat) begin
        // Wraps back to slot 0 after the last bin since BUFFER_SIZE is a power of two
        r_rd_idx <= r_rd_idx + 1'b1;
      end
      if (w_done) begin
        r_frame_count <= r_frame_count + 1'b1;
      end
    end
  end

  assign idle        = (r_state == OUT_IDLE);
  assign out_valid   = (r_state == OUT_DRAIN);
  assign out_data    = r_bins[r_rd_idx*SAMPLE_SIZE +: SAMPLE_SIZE];
  assign out_index   = r_rd_idx;
  assign out_last    = (r_state == OUT_DRAIN) && (r_rd_idx == LAST_IDX);
  assign frame_count = r_frame_count;

endmodule

// File: rtl/fft_frame_controller.sv
// rtl/fft_frame_controller.sv - frame assembly and sequencing around a combinational FFT
module fft_frame_controller
  import fft_ctrl_pkg::*;
#(
  parameter int SAMPLE_SIZE   = 32,
  parameter int BUFFER_SIZE   = 32,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [SAMPLE_SIZE-1:0]               in_sample,
  output logic [SAMPLE_SIZE*BUFFER_SIZE-1:0]   fft_in,
  input  logic [SAMPLE_SIZE*BUFFER_SIZE-1:0]   fft_out,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [SAMPLE_SIZE-1:0]               out_data,
  output logic [sample_idx_w(BUFFER_SIZE)-1:0] out_index,
  output logic                                 out_last,
  output logic [FRAME_CNT_W-1:0]               frame_count
);

  localparam int               IDX_W       = sample_idx_w(BUFFER_SIZE);
  localparam int               CNT_W       = $clog2(SETTLE_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_SLOT   = IDX_W'(BUFFER_SIZE - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  in_state_t                          r_state;
  in_state_t                          w_state_nxt;
  logic [IDX_W-1:0]                   r_wr_idx;
  logic [CNT_W-1:0]                   r_settle_cnt;
  logic [SAMPLE_SIZE*BUFFER_SIZE-1:0] r_frame;
  logic                               w_accept;
  logic                               w_frame_full;
  logic                               w_settled;
  logic                               w_out_idle;
  logic                               w_capture;

  assign w_accept     = (r_state == IN_FILL) && in_valid;
  assign w_frame_full = w_accept && (r_wr_idx == LAST_SLOT);
  // The count reaches zero on the same edge the FSM enters HOLD
  assign w_settled    = (r_state == IN_SETTLE) && (r_settle_cnt == CNT_ONE);
  // Drain side is seen idle one cycle after its last beat; no bypass path
  assign w_capture    = (r_state == IN_HOLD) && w_out_idle;

  // Input FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IN_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Input FSM next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IN_IDLE:   w_state_nxt = IN_FILL;
      IN_FILL:   if (w_frame_full) w_state_nxt = IN_SETTLE;
      IN_SETTLE: if (w_settled)    w_state_nxt = IN_HOLD;
      IN_HOLD:   if (w_capture)    w_state_nxt = IN_FILL;
      default:   w_state_nxt = IN_IDLE;
    endcase
  end

  // Frame assembly: fft_in only moves on accepted samples, so it holds through SETTLE and HOLD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame  <= '0;
      r_wr_idx <= '0;
    end else if (w_accept) begin
      r_frame[r_wr_idx*SAMPLE_SIZE +: SAMPLE_SIZE] <= in_sample;
      r_wr_idx <= w_frame_full ? '0 : r_wr_idx + 1'b1;
    end
  end

  // Settle counter: loaded with the final sample, counts down while in SETTLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_settle_cnt <= '0;
    end else if (w_frame_full) begin
      r_settle_cnt <= SETTLE_LOAD;
    end else if ((r_state == IN_SETTLE) && (r_settle_cnt != '0)) begin
      r_settle_cnt <= r_settle_cnt - 1'b1;
    end
  end

  assign in_ready = (r_state == IN_FILL);
  assign fft_in   = r_frame;

  fft_bin_streamer #(
    .SAMPLE_SIZE (SAMPLE_SIZE),
    .BUFFER_SIZE (BUFFER_SIZE)
  ) u_streamer (
    .clk         (clk),
    .rst_n       (rst_n),
    .capture     (w_capture),
    .frame_in    (fft_out),
    .idle        (w_out_idle),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_index   (out_index),
    .out_last    (out_last),
    .frame_count (frame_count)
  );

endmodule

// File: doc/fft_frame_controller.md
# fft_frame_controller

Sequencer wrapped around the combinational `FFT_Top` datapath. It does three jobs:
- accepts a stream of audio samples over a valid/ready handshake and assembles a frame of `BUFFER_SIZE` samples into the packed `input_bitstream` word;
- holds that frame stable for a fixed settle time, then captures `output_bitstream` into an output register;
- streams the captured bins out one per handshake.

Input filling of the next frame overlaps draining of the previous one.

## Interface
Parameters:
- `SAMPLE_SIZE`, 32: width of one sample and one output bin, signed.
- `BUFFER_SIZE`, 32: samples per frame; power of two, ≥ 2.
- `SETTLE_CYCLES`, 2: full clock cycles the FFT input is held stable before capture; ≥ 1.

Ports:
- `clk` input, 1: the single clock.
- `rst_n` input, 1: asynchronous, active-low reset.
- `in_valid` input, 1: `in_sample` is valid.
- `in_ready` output, 1: controller accepts a sample this cycle.
- `in_sample` input, `SAMPLE_SIZE`: signed audio sample.
- `fft_in` output, `SAMPLE_SIZE*BUFFER_SIZE`: drives `FFT_Top.input_bitstream`. Sample k sits at `[k*SAMPLE_SIZE +: SAMPLE_SIZE]`.
- `fft_out` input, `SAMPLE_SIZE*BUFFER_SIZE`: from `FFT_Top.output_bitstream`.
- `out_valid` output, 1: `out_data` holds a bin.
- `out_ready` input, 1: consumer accepts the bin.
- `out_data` output, `SAMPLE_SIZE`: current bin.
- `out_index` output, `$clog2(BUFFER_SIZE)`: bin number of `out_data`.
- `out_last` output, 1: asserted with the final bin of a frame.
- `frame_count` output, 16: frames fully drained; wraps at 65535 → 0.

## Operation
Input FSM, states IDLE, FILL, SETTLE, HOLD:
- **IDLE.** Reset state. Moves to FILL unconditionally on the next edge.
- **FILL.** `in_ready`=1. On `in_valid && in_ready`, the sample is written to slot `wr_idx` and `wr_idx` increments.
  - Accepting slot `BUFFER_SIZE-1` moves to SETTLE, clears `wr_idx` and loads the settle counter with `SETTLE_CYCLES`.
- **SETTLE.** `in_ready`=0. The counter decrements each cycle; at 0 the FSM moves to HOLD.
- **HOLD.** `in_ready`=0.
  - If the output side is IDLE: capture `fft_out` into the output register this edge, then go to FILL.
  - Otherwise remain in HOLD.
- `fft_in` changes only on FILL writes. It is constant from the last accepted sample until the next frame's first write.

Output FSM, states IDLE, DRAIN:
- **IDLE.** `out_valid`=0. A capture moves it to DRAIN with `rd_idx`=0.
- **DRAIN.**
  - `out_valid`=1, `out_data` = captured slot `rd_idx`, `out_index` = `rd_idx`, `out_last` = (`rd_idx` == `BUFFER_SIZE-1`).
  - `out_ready` is sampled each cycle. On a handshake, `rd_idx` increments.
  - A handshake with `out_last` moves to IDLE and increments `frame_count`.
- `out_data` and `out_index` are stable while `out_valid && !out_ready`.

Boundaries:
- **Last beat in the same cycle HOLD is entered:** the output side reads IDLE only on the following cycle, so capture occurs one cycle later. No bypass.
- **`in_valid` while `in_ready`=0:** ignored; the source must hold the sample.
- **Reset asserted mid-frame:** both FSMs return to IDLE immediately. Partial input is discarded; an in-flight drain is aborted.

## Timing
- Reset values:
  - `in_ready`=0, `out_valid`=0, `out_last`=0, `out_index`=0, `out_data`=0, `frame_count`=0.
  - `fft_in` = all zeros.
- `in_ready` first rises one cycle after `rst_n` deasserts.
- All outputs are registered, or decoded from registered state only. No combinational path from `in_valid` or `out_ready` to any output.
- Last input accept (edge t) → SETTLE occupies edges t+1 … t+`SETTLE_CYCLES` → HOLD at edge t+`SETTLE_CYCLES`.
  - With output IDLE, capture is at edge t+`SETTLE_CYCLES`+1.
  - `out_valid` is high from that edge.
- Minimum frame period: `BUFFER_SIZE` + `SETTLE_CYCLES` + 1 cycles. This rate is sustained when the consumer holds `out_ready`=1.

## Structure
- Package `fft_ctrl_pkg` holds:
  - `in_state_t` (IDLE/FILL/SETTLE/HOLD) and `out_state_t` (IDLE/DRAIN) enums;
  - the frame-counter width constant;
  - a sample-index function computing `$clog2(BUFFER_SIZE)`.
- One sub-module, `fft_bin_streamer`: contains the capture register, `rd_idx`, the output FSM, `out_*` and `frame_count`. It exports `idle` and accepts a `capture` pulse.
- The top contains the input FSM, the frame assembly register and the settle counter.

## Test plan
- **Reset and first frame.** Assert `rst_n`=0 with `in_valid`=1. Expect `in_ready`=0 and all outputs at reset values. Release reset: `in_ready`=1 one cycle later.
- **Full frame with identity FFT stub** (`fft_out` = `fft_in`). Feed `in_sample` = 1000·sin(k), truncated, for k = 0..31 with `out_ready`=1.
  - Capture 3 cycles after the 32nd accept.
  - Bins 0..31 equal the inputs; `out_last` only on index 31; `frame_count`=1.
- **Output backpressure.** `out_ready`=0 for 10 cycles at index 5: `out_data` and `out_index`=5 hold stable, no index skipped.
- **Overlap and hold.** Fill frame 2 while frame 1 drains with `out_ready`=1 every 4th cycle.
  - Frame 2 waits in HOLD with `in_ready`=0.
  - Capture occurs exactly 1 cycle after frame 1's last handshake.
- **Input gaps.** Toggle `in_valid` every cycle: exactly 32 accepts, samples land in slots 0..31 in order.
- **Mid-drain reset.** Pulse `rst_n` low at index 17: `out_valid`=0 and `frame_count`=0 immediately; the next frame restarts at slot 0.
